// File: rtl/ram_burst_master.sv
// Burst initiator for the single-port RAM word interface: one write or read
// burst of 1..MAX_LEN consecutive words at a time, streamed over valid/ready.
module ram_burst_master #(
    parameter int MEM_WORDS = 1048576,
    parameter int MAX_LEN   = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic        cmd_write,
    input  logic [31:0] cmd_addr,
    input  logic [4:0]  cmd_len,
    input  logic        wr_valid,
    output logic        wr_ready,
    input  logic [31:0] wr_data,
    output logic        rd_valid,
    input  logic        rd_ready,
    output logic [31:0] rd_data,
    output logic        done,
    output logic        err,
    output logic        ram_load,
    output logic        ram_save,
    output logic [31:0] ram_addr,
    output logic [31:0] ram_data,
    input  logic [31:0] ram_value
);

    localparam logic [4:0]  MAX_LEN_W = 5'(MAX_LEN);
    localparam logic [32:0] MEM_LIMIT = 33'(MEM_WORDS);

    typedef enum logic [2:0] {IDLE, WRITE, READ, DONE, ERR} state_t;

    state_t      state, state_next;
    logic [31:0] cur_addr, cur_addr_next;
    logic [4:0]  remaining, remaining_next;
    logic [4:0]  issue_left, issue_left_next;
    logic [4:0]  resp_left, resp_left_next;
    logic        hold, hold_next;
    logic [32:0] end_addr;
    logic        legal;

    // 33-bit sum so a command that wraps past 2^32 is rejected too
    assign end_addr = {1'b0, cmd_addr} + {28'd0, cmd_len};
    assign legal    = (cmd_len != 5'd0) && (cmd_len <= MAX_LEN_W) && (end_addr <= MEM_LIMIT);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            cur_addr   <= '0;
            remaining  <= '0;
            issue_left <= '0;
            resp_left  <= '0;
            hold       <= 1'b0;
        end else begin
            state      <= state_next;
            cur_addr   <= cur_addr_next;
            remaining  <= remaining_next;
            issue_left <= issue_left_next;
            resp_left  <= resp_left_next;
            hold       <= hold_next;
        end
    end

    always_comb begin
        state_next      = state;
        cur_addr_next   = cur_addr;
        remaining_next  = remaining;
        issue_left_next = issue_left;
        resp_left_next  = resp_left;
        hold_next       = 1'b0;
        cmd_ready       = 1'b0;
        wr_ready        = 1'b0;
        rd_valid        = 1'b0;
        rd_data         = '0;
        done            = 1'b0;
        err             = 1'b0;
        ram_load        = 1'b0;
        ram_save        = 1'b0;
        ram_addr        = '0;
        ram_data        = '0;

        case (state)
            IDLE: begin
                cmd_ready = 1'b1;
                if (cmd_valid) begin
                    cur_addr_next = cmd_addr;
                    if (!legal) begin
                        state_next = ERR;
                    end else if (cmd_write) begin
                        state_next     = WRITE;
                        remaining_next = cmd_len;
                    end else begin
                        state_next      = READ;
                        issue_left_next = cmd_len;
                        resp_left_next  = cmd_len;
                    end
                end
            end

            WRITE: begin
                wr_ready = 1'b1;
                ram_save = wr_valid;
                ram_addr = cur_addr;
                ram_data = wr_data;
                if (wr_valid) begin
                    cur_addr_next  = cur_addr + 32'd1;
                    remaining_next = remaining - 5'd1;
                    if (remaining == 5'd1) begin
                        state_next = DONE;
                    end
                end
            end

            READ: begin
                ram_addr = cur_addr;
                rd_valid = hold;
                // RAM value only moves on a load edge, so it is the held word
                rd_data  = hold ? ram_value : '0;
                ram_load = (issue_left != 5'd0) && (!hold || rd_ready);
                if (ram_load) begin
                    cur_addr_next   = cur_addr + 32'd1;
                    issue_left_next = issue_left - 5'd1;
                end
                hold_next = ram_load || (hold && !rd_ready);
                if (hold && rd_ready) begin
                    resp_left_next = resp_left - 5'd1;
                    if (resp_left == 5'd1) begin
                        state_next = DONE;
                    end
                end
            end

            DONE: begin
                done       = 1'b1;
                state_next = IDLE;
            end

            ERR: begin
                err        = 1'b1;
                state_next = IDLE;
            end

            default: state_next = IDLE;
        endcase
    end

endmodule

// File: tb/tb_ram_burst_master.sv
// Self-checking bench for ram_burst_master: directed scenarios plus random
// commands checked against a word-array reference of expected RAM contents.
module tb_ram_burst_master;

    localparam int MEM_WORDS = 1048576;
    localparam int MAX_LEN   = 16;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cmd_valid, cmd_ready, cmd_write;
    logic [31:0] cmd_addr;
    logic [4:0]  cmd_len;
    logic        wr_valid, wr_ready;
    logic [31:0] wr_data;
    logic        rd_valid, rd_ready;
    logic [31:0] rd_data;
    logic        done, err;
    logic        ram_load, ram_save;
    logic [31:0] ram_addr, ram_data;
    logic [31:0] ram_value = '0;

    int tests_run    = 0;
    int tests_failed = 0;

    bit [31:0] ram_mem [bit [31:0]];
    bit [31:0] ref_mem [bit [31:0]];
    bit [31:0] wr_words [$];

    always #5 clk = ~clk;

    ram_burst_master #(.MEM_WORDS(MEM_WORDS), .MAX_LEN(MAX_LEN)) dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_len(cmd_len),
        .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data),
        .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data),
        .done(done), .err(err),
        .ram_load(ram_load), .ram_save(ram_save), .ram_addr(ram_addr),
        .ram_data(ram_data), .ram_value(ram_value)
    );

    // RAM behaviour: save writes the word, load registers the addressed word
    always @(posedge clk) begin
        if (ram_save) ram_mem[ram_addr] = ram_data;
        if (ram_load) ram_value <= ram_mem.exists(ram_addr) ? ram_mem[ram_addr] : 32'd0;
    end

    function automatic bit [31:0] ref_word(input bit [31:0] a);
        return ref_mem.exists(a) ? ref_mem[a] : 32'd0;
    endfunction

    function automatic bit [31:0] ram_word(input bit [31:0] a);
        return ram_mem.exists(a) ? ram_mem[a] : 32'd0;
    endfunction

    function automatic bit is_legal(input bit [31:0] a, input int len);
        longint unsigned last;
        last = a;
        last = last + longint'(len);
        return (len >= 1) && (len <= MAX_LEN) && (last <= longint'(MEM_WORDS));
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_output(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        tests_run++;
        assert (observed === expected) else begin
            tests_failed++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    task automatic issue_cmd(input bit write, input bit [31:0] addr, input int len);
        cmd_valid = 1'b1;
        cmd_write = write;
        cmd_addr  = addr;
        cmd_len   = 5'(len);
        #1;
        check_output("cmd_ready_idle", cmd_ready, 1);
        step();
        cmd_valid = 1'b0;
    endtask

    // mode 0: no gaps, 1: wr_valid 1,0,1,0.. with cmd_valid pulses, 2: random gaps
    task automatic run_write(input bit [31:0] addr, input int len, input int mode);
        int idx = 0;
        int cyc = 1;
        bit v;
        issue_cmd(1'b1, addr, len);
        while (idx < len && cyc < 100) begin
            case (mode)
                0:       v = 1'b1;
                1:       v = ((cyc - 1) % 2 == 0);
                default: v = ($urandom_range(0, 3) != 0);
            endcase
            wr_valid = v;
            wr_data  = v ? wr_words[idx] : $urandom;
            if (mode == 1) begin
                cmd_valid = 1'b1;
                cmd_write = 1'b0;
                cmd_addr  = $urandom;
                cmd_len   = 5'd1;
            end
            #1;
            check_output("wr_ready", wr_ready, 1);
            check_output("wr_ram_save", ram_save, v);
            check_output("wr_ram_load", ram_load, 0);
            check_output("wr_done_early", done, 0);
            if (mode == 1) check_output("wr_cmd_ignored", cmd_ready, 0);
            if (v) begin
                check_output("wr_ram_addr", ram_addr, addr + 32'(idx));
                check_output("wr_ram_data", ram_data, wr_words[idx]);
                ref_mem[addr + 32'(idx)] = wr_words[idx];
                idx++;
            end
            step();
            cyc++;
        end
        wr_valid  = 1'b0;
        cmd_valid = 1'b0;
        check_output("write_words", 32'(idx), 32'(len));
        #1;
        check_output("write_done", done, 1);
        check_output("write_done_no_save", ram_save, 0);
        if (mode == 0) check_output("write_done_cycle", 32'(cyc), 32'(len + 1));
        step();
        check_output("write_cmd_ready_back", cmd_ready, 1);
        check_output("write_done_pulse", done, 0);
    endtask

    // mode 0: rd_ready held, 1: rd_ready low in cycles 3..5, 2: random stalls
    task automatic run_read(input bit [31:0] addr, input int len, input int mode);
        int delivered = 0;
        int loads     = 0;
        int cyc       = 1;
        int first_valid = -1;
        bit r;
        issue_cmd(1'b0, addr, len);
        while (delivered < len && cyc < 150) begin
            case (mode)
                0:       r = 1'b1;
                1:       r = !(cyc >= 3 && cyc <= 5);
                default: r = ($urandom_range(0, 2) != 0);
            endcase
            rd_ready = r;
            #1;
            check_output("rd_ram_save", ram_save, 0);
            check_output("rd_done_early", done, 0);
            if (rd_valid && !r) check_output("rd_load_while_stalled", ram_load, 0);
            if (mode == 0) check_output("rd_load_window", ram_load, (cyc <= len));
            if (ram_load) begin
                check_output("rd_ram_addr", ram_addr, addr + 32'(loads));
                loads++;
            end
            if (rd_valid) begin
                if (first_valid < 0) first_valid = cyc;
                check_output("rd_data", rd_data, ref_word(addr + 32'(delivered)));
                if (r) delivered++;
            end
            step();
            cyc++;
        end
        rd_ready = 1'b0;
        #1;
        check_output("read_words", 32'(delivered), 32'(len));
        check_output("read_loads", 32'(loads), 32'(len));
        check_output("read_done", done, 1);
        check_output("read_done_no_valid", rd_valid, 0);
        check_output("read_done_no_load", ram_load, 0);
        if (mode == 0) begin
            check_output("read_first_valid_cycle", 32'(first_valid), 32'd2);
            check_output("read_done_cycle", 32'(cyc), 32'(len + 2));
        end
        step();
        check_output("read_cmd_ready_back", cmd_ready, 1);
        check_output("read_done_pulse", done, 0);
    endtask

    task automatic run_illegal(input bit write, input bit [31:0] addr, input int len);
        issue_cmd(write, addr, len);
        #1;
        check_output("ill_err", err, 1);
        check_output("ill_no_load", ram_load, 0);
        check_output("ill_no_save", ram_save, 0);
        check_output("ill_cmd_ready_low", cmd_ready, 0);
        check_output("ill_no_done", done, 0);
        step();
        check_output("ill_cmd_ready_back", cmd_ready, 1);
        check_output("ill_err_pulse", err, 0);
    endtask

    task automatic fill_words(input int len, input bit [31:0] base, input bit random_data);
        wr_words.delete();
        for (int i = 0; i < len; i++) begin
            wr_words.push_back(random_data ? $urandom : base + 32'(i));
        end
    endtask

    initial begin
        rst_n     = 1'b0;
        cmd_valid = 1'b0;
        cmd_write = 1'b0;
        cmd_addr  = '0;
        cmd_len   = '0;
        wr_valid  = 1'b0;
        wr_data   = 32'hDEADBEEF;
        rd_ready  = 1'b0;
        step();
        step();
        rst_n = 1'b1;
        #1;
        check_output("rst_cmd_ready", cmd_ready, 1);
        check_output("rst_wr_ready", wr_ready, 0);
        check_output("rst_rd_valid", rd_valid, 0);
        check_output("rst_done", done, 0);
        check_output("rst_err", err, 0);
        check_output("rst_ram_load", ram_load, 0);
        check_output("rst_ram_save", ram_save, 0);
        check_output("rst_ram_addr", ram_addr, 0);
        check_output("rst_ram_data", ram_data, 0);
        check_output("rst_rd_data", rd_data, 0);
        step();

        fill_words(4, 32'hA0, 1'b0);
        run_write(32'h100, 4, 0);
        for (int i = 0; i < 4; i++) begin
            check_output("ram_contents", ram_word(32'h100 + 32'(i)), 32'hA0 + 32'(i));
        end
        run_read(32'h100, 4, 0);
        run_read(32'h100, 4, 1);

        run_illegal(1'b0, 32'h100, 0);
        run_illegal(1'b1, 32'h100, 17);
        run_illegal(1'b0, 32'(MEM_WORDS - 2), 4);
        run_illegal(1'b1, 32'hFFFFFFFF, 2);

        fill_words(3, 32'h300, 1'b0);
        run_write(32'h300, 3, 1);
        run_read(32'h300, 3, 0);

        fill_words(4, 32'h0, 1'b1);
        run_write(32'(MEM_WORDS - 4), 4, 0);
        run_read(32'(MEM_WORDS - 4), 4, 0);
        fill_words(16, 32'h0, 1'b1);
        run_write(32'h400, 16, 2);
        run_read(32'h400, 16, 2);

        // reset in the middle of an 8-word read
        fill_words(8, 32'h0, 1'b1);
        run_write(32'h200, 8, 0);
        rd_ready = 1'b1;
        issue_cmd(1'b0, 32'h200, 8);
        step();
        step();
        rst_n = 1'b0;
        #1;
        check_output("mid_rst_rd_valid", rd_valid, 0);
        check_output("mid_rst_ram_load", ram_load, 0);
        check_output("mid_rst_ram_addr", ram_addr, 0);
        check_output("mid_rst_rd_data", rd_data, 0);
        check_output("mid_rst_done", done, 0);
        check_output("mid_rst_err", err, 0);
        step();
        rst_n    = 1'b1;
        rd_ready = 1'b0;
        #1;
        for (int i = 0; i < 3; i++) begin
            check_output("post_rst_cmd_ready", cmd_ready, 1);
            check_output("post_rst_no_done", done, 0);
            step();
        end
        run_read(32'h200, 8, 0);

        for (int n = 0; n < 40; n++) begin
            int sel;
            int len;
            bit write;
            bit [31:0] addr;
            sel   = $urandom_range(0, 9);
            len   = $urandom_range(0, 18);
            write = 1'($urandom_range(0, 1));
            if (sel < 6)      addr = 32'($urandom_range(0, 40));
            else if (sel < 8) addr = 32'(MEM_WORDS) - 32'($urandom_range(0, 20));
            else              addr = $urandom;
            if (!is_legal(addr, len)) begin
                run_illegal(write, addr, len);
            end else if (write) begin
                fill_words(len, 32'h0, 1'b1);
                run_write(addr, len, 2);
            end else begin
                run_read(addr, len, 2);
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
